// File: rtl/ultrasonic_ranger_avg.sv
// HC-SR04-class ranging engine: trigger/echo timing at 1 us resolution,
// rolling average over 2^AVG_LOG2 samples, sequential divide to centimetres.
module ultrasonic_ranger_avg #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int TRIG_US    = 10,
    parameter int TIMEOUT_US = 30_000,
    parameter int GAP_US     = 60_000,
    parameter int AVG_LOG2   = 2,
    parameter int CNT_W      = 16
) (
    input  logic        clk,
    input  logic        reset_p,
    input  logic        enable,
    input  logic        echo,
    output logic        trigger,
    output logic [15:0] distance_cm,
    output logic        distance_valid,
    output logic        timeout,
    output logic        no_echo
);
    localparam int DIV    = CLK_HZ / 1_000_000;
    localparam int PW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DEPTH  = 1 << AVG_LOG2;
    localparam int PTR_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int FILL_W = AVG_LOG2 + 1;
    localparam int SUM_W  = CNT_W + AVG_LOG2;
    localparam int DC_W   = $clog2(CNT_W);

    typedef enum logic [2:0] {
        IDLE, TRIG, WAIT_RISE, MEASURE, UPDATE, DIVIDE, DONE, HOLDOFF
    } state_t;

    state_t state, state_nx;

    logic [2:0]        echo_sh;
    logic              rise, fall;
    logic [PW-1:0]     presc;
    logic              tick;
    logic [CNT_W-1:0]  us_cnt, us_inc;
    logic              trig_done, to_hit, gap_done, to_fire;
    logic [CNT_W-1:0]  sample;
    logic [CNT_W-1:0]  ring [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [FILL_W-1:0] fill;
    logic              full;
    logic [SUM_W-1:0]  sum, sum_nx, old;
    logic [CNT_W-1:0]  dvd, quo, quo_nx;
    logic [5:0]        rem;
    logic [6:0]        trial, trial_sub;
    logic              q_bit;
    logic [DC_W-1:0]   div_cnt;
    logic              div_last;
    logic [31:0]       quo_ext;

    assign tick      = (presc == PW'(DIV - 1));
    assign us_inc    = (tick && !(&us_cnt)) ? us_cnt + 1'b1 : us_cnt;
    assign trig_done = tick && (us_cnt == CNT_W'(TRIG_US - 1));
    assign to_hit    = tick && (us_cnt == CNT_W'(TIMEOUT_US - 1));
    assign gap_done  = tick && (us_cnt == CNT_W'(GAP_US - 1));

    // Slot wr_ptr holds a live sample only once the ring has wrapped.
    assign full   = (fill == FILL_W'(DEPTH));
    assign old    = full ? SUM_W'(ring[wr_ptr]) : '0;
    assign sum_nx = sum - old + SUM_W'(sample);

    assign trial     = {rem, dvd[CNT_W-1]};
    assign trial_sub = trial - 7'd58;
    assign q_bit     = (trial >= 7'd58);
    assign quo_nx    = {quo[CNT_W-2:0], q_bit};
    assign quo_ext   = 32'(quo_nx);
    assign div_last  = (div_cnt == DC_W'(CNT_W - 1));

    always_comb begin
        state_nx = state;
        trigger  = 1'b0;
        to_fire  = 1'b0;
        case (state)
            IDLE:      if (enable) state_nx = TRIG;
            TRIG: begin
                trigger = 1'b1;
                if (trig_done) state_nx = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (rise) state_nx = MEASURE;
                else if (to_hit) begin
                    to_fire  = 1'b1;
                    state_nx = HOLDOFF;
                end
            end
            MEASURE: begin
                if (fall) state_nx = UPDATE;
                else if (to_hit) begin
                    to_fire  = 1'b1;
                    state_nx = HOLDOFF;
                end
            end
            UPDATE:    state_nx = (fill < FILL_W'(DEPTH - 1)) ? HOLDOFF : DIVIDE;
            DIVIDE:    if (div_last) state_nx = DONE;
            DONE:      state_nx = HOLDOFF;
            HOLDOFF:   if (gap_done) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state   <= IDLE;
            echo_sh <= '0;
            rise    <= 1'b0;
            fall    <= 1'b0;
            presc   <= '0;
            us_cnt  <= '0;
        end else begin
            state   <= state_nx;
            echo_sh <= {echo_sh[1:0], echo};
            rise    <= echo_sh[1] & ~echo_sh[2];
            fall    <= ~echo_sh[1] & echo_sh[2];
            // Timebase restarts on every state entry so intervals are whole us.
            if (state_nx != state) begin
                presc  <= '0;
                us_cnt <= '0;
            end else begin
                presc  <= tick ? '0 : presc + 1'b1;
                us_cnt <= us_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            sample         <= '0;
            sum            <= '0;
            fill           <= '0;
            wr_ptr         <= '0;
            dvd            <= '0;
            quo            <= '0;
            rem            <= '0;
            div_cnt        <= '0;
            distance_cm    <= '0;
            distance_valid <= 1'b0;
            timeout        <= 1'b0;
            no_echo        <= 1'b0;
        end else begin
            distance_valid <= 1'b0;
            timeout        <= to_fire;
            if (to_fire) no_echo <= 1'b1;
            // MEASURE is entered one cycle after the rise, so take the
            // count including this cycle to keep rise/fall symmetric.
            if (state == MEASURE && fall) sample <= us_inc;
            if (state == UPDATE) begin
                no_echo <= 1'b0;
                sum     <= sum_nx;
                wr_ptr  <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
                if (!full) fill <= fill + 1'b1;
                dvd     <= CNT_W'(sum_nx >> AVG_LOG2);
                quo     <= '0;
                rem     <= '0;
                div_cnt <= '0;
            end
            if (state == DIVIDE) begin
                rem     <= q_bit ? trial_sub[5:0] : trial[5:0];
                quo     <= quo_nx;
                dvd     <= {dvd[CNT_W-2:0], 1'b0};
                div_cnt <= div_cnt + 1'b1;
                if (div_last) begin
                    distance_cm    <= quo_ext[15:0];
                    distance_valid <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == UPDATE) ring[wr_ptr] <= sample;
    end

endmodule
